// File: rtl/tiwen_link_pkg.sv
// Shared definitions for the tiwen UART link: header bytes, frame length, frame-FSM states, checksum.
// Used by both the transmit framer and the receive parser so the two ends stay in agreement.
package tiwen_link_pkg;

   localparam logic [7:0] HDR0_DEF  = 8'hA5;
   localparam logic [7:0] HDR1_DEF  = 8'h5A;
   localparam int         FRAME_LEN = 5;
   localparam logic [2:0] LAST_BYTE = 3'(FRAME_LEN - 1);

   typedef enum logic [2:0] {
      FR_IDLE,
      FR_LOAD,
      FR_SEND,
      FR_WAIT,
      FR_GAP,
      FR_DONE
   } frame_state_e;

   // Checksum is the 8-bit wrapping sum of the two payload bytes; the carry is dropped.
   function automatic logic [7:0] frame_checksum(input logic [7:0] hi, input logic [7:0] lo);
      return hi + lo;
   endfunction

endpackage

// File: rtl/tiwen_tx_frame_if.sv
// Request/status bundle of the tiwen frame transmitter: start + word in, serial line and status out.
// No backpressure beyond busy; a start seen while busy is dropped.
interface tiwen_tx_frame_if;
   logic        start;
   logic [15:0] tiwen;
   logic        RS232_TX;
   logic        busy;
   logic        Tx_done;

   modport master (output start, tiwen, input RS232_TX, busy, Tx_done);
   modport slave  (input start, tiwen, output RS232_TX, busy, Tx_done);
endinterface

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: line falls one clk after tx_start, byte occupies 10*CLKS_PER_BIT clks.
// tx_start is ignored while tx_busy; tx_done is high during the final clk of the stop bit.
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 5208
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_start,
   input  logic [7:0] tx_data,
   output logic       tx_line,
   output logic       tx_busy,
   output logic       tx_done
);

   localparam int             CNT_W     = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] BAUD_PRE  = CNT_W'(CLKS_PER_BIT - 2);
   localparam logic [3:0]     STOP_BIT  = 4'd9;
   localparam logic [3:0]     LAST_DATA = 4'd8;

   logic [CNT_W-1:0] baud_q, baud_d;
   logic [3:0]       bit_q, bit_d;
   logic [7:0]       shift_q, shift_d;
   logic             line_q, line_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;

   always_comb begin
      baud_d  = baud_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      line_d  = line_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      if (!busy_q) begin
         if (tx_start) begin
            line_d  = 1'b0;
            shift_d = tx_data;
            baud_d  = '0;
            bit_d   = 4'd0;
            busy_d  = 1'b1;
         end
      end else begin
         // Flag the last clk of the stop bit so the framer can react on the closing edge itself.
         done_d = (bit_q == STOP_BIT) && (baud_q == BAUD_PRE);
         if (baud_q == BAUD_LAST) begin
            baud_d = '0;
            if (bit_q == STOP_BIT) begin
               busy_d = 1'b0;
            end else begin
               bit_d = bit_q + 4'd1;
               if (bit_q == LAST_DATA) begin
                  line_d = 1'b1;
               end else begin
                  line_d  = shift_q[0];
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end
         end else begin
            baud_d = baud_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         baud_q  <= '0;
         bit_q   <= 4'd0;
         shift_q <= 8'h00;
         line_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         line_q  <= line_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign tx_line = line_q;
   assign tx_busy = busy_q;
   assign tx_done = done_q;

endmodule

// File: rtl/tiwen_tx_frame.sv
// Frames a 16-bit tiwen word as HDR0,HDR1,hi,lo,sum and sends it 8N1; first start bit 2 clks after accept.
// start is only honoured while busy is low; requests during a frame are dropped, not queued.
module tiwen_tx_frame
   import tiwen_link_pkg::*;
#(
   parameter int         CLK_FREQ = 50_000_000,
   parameter int         BAUD     = 9600,
   parameter logic [7:0] HDR0     = HDR0_DEF,
   parameter logic [7:0] HDR1     = HDR1_DEF
) (
   input logic              clk,
   input logic              rst,
   tiwen_tx_frame_if.slave  bus
);

   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

   frame_state_e state_q;
   logic [2:0]   k_q;
   logic [15:0]  tiwen_q;
   logic         busy_q;
   logic         done_q;
   logic         kick_q;
   logic [7:0]   byte_dat;
   logic         byte_line;
   logic         byte_busy;
   logic         byte_done;
   logic         accept;

   assign accept = bus.start && !busy_q;

   always_comb begin
      byte_dat = frame_checksum(tiwen_q[15:8], tiwen_q[7:0]);
      case (k_q)
         3'd0:    byte_dat = HDR0;
         3'd1:    byte_dat = HDR1;
         3'd2:    byte_dat = tiwen_q[15:8];
         3'd3:    byte_dat = tiwen_q[7:0];
         default: byte_dat = frame_checksum(tiwen_q[15:8], tiwen_q[7:0]);
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= FR_IDLE;
         k_q     <= 3'd0;
         tiwen_q <= 16'h0000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         kick_q  <= 1'b0;
      end else begin
         case (state_q)
            FR_IDLE: begin
               k_q <= 3'd0;
               if (accept) begin
                  tiwen_q <= bus.tiwen;
                  busy_q  <= 1'b1;
                  state_q <= FR_LOAD;
               end
            end
            FR_LOAD: begin
               kick_q  <= 1'b1;
               state_q <= FR_SEND;
            end
            FR_SEND: begin
               kick_q  <= 1'b0;
               state_q <= FR_WAIT;
            end
            FR_WAIT: begin
               if (byte_done) begin
                  if (k_q == LAST_BYTE) begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= FR_DONE;
                  end else begin
                     k_q     <= k_q + 3'd1;
                     state_q <= FR_GAP;
                  end
               end
            end
            FR_GAP: begin
               if (!byte_busy) begin
                  kick_q  <= 1'b1;
                  state_q <= FR_SEND;
               end
            end
            FR_DONE: begin
               // busy is already low here, so a start in the Tx_done cycle opens the next frame.
               done_q <= 1'b0;
               k_q    <= 3'd0;
               if (accept) begin
                  tiwen_q <= bus.tiwen;
                  busy_q  <= 1'b1;
                  state_q <= FR_LOAD;
               end else begin
                  state_q <= FR_IDLE;
               end
            end
            default: state_q <= FR_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_byte (
      .clk      (clk),
      .rst      (rst),
      .tx_start (kick_q),
      .tx_data  (byte_dat),
      .tx_line  (byte_line),
      .tx_busy  (byte_busy),
      .tx_done  (byte_done)
   );

   assign bus.RS232_TX = byte_line;
   assign bus.busy     = busy_q;
   assign bus.Tx_done  = done_q;

endmodule

// File: tb/tb_tiwen_tx_frame.sv
// Bench for tiwen_tx_frame at 10 clks per bit: waveform and mid-bit decode checked against a frame model.
module tb_tiwen_tx_frame;

   localparam int CPB       = 10;
   localparam int BYTE_CLKS = 10 * CPB;
   localparam int SLOT      = BYTE_CLKS + 2;
   localparam int FRAME_END = 2 + 5 * BYTE_CLKS + 4 * 2;
   localparam int LOG_N     = 2048;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   total = 0;
   int   bad   = 0;

   logic ln [0:LOG_N-1];
   logic bz [0:LOG_N-1];
   logic dn [0:LOG_N-1];

   tiwen_tx_frame_if bus ();

   tiwen_tx_frame #(
      .CLK_FREQ (1_000_000),
      .BAUD     (100_000),
      .HDR0     (8'hA5),
      .HDR1     (8'h5A)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] exp_byte(input logic [15:0] tw, input int k);
      int hi;
      int lo;
      hi = int'(tw) / 256;
      lo = int'(tw) % 256;
      case (k)
         0:       return 8'hA5;
         1:       return 8'h5A;
         2:       return 8'(hi);
         3:       return 8'(lo);
         default: return 8'((hi + lo) % 256);
      endcase
   endfunction

   // Expected line level j clks after the accept edge.
   function automatic logic exp_line(input logic [15:0] tw, input int j);
      int m;
      int p;
      int b;
      logic [7:0] v;
      if (j < 2 || j >= FRAME_END) return 1'b1;
      m = j - 2;
      p = m % SLOT;
      if (p >= BYTE_CLKS) return 1'b1;
      b = p / CPB;
      if (b == 0) return 1'b0;
      if (b == 9) return 1'b1;
      v = exp_byte(tw, m / SLOT);
      return v[b-1];
   endfunction

   task automatic run_frame(input logic [15:0] tw1, input int change_at, input logic [15:0] tw2,
                            input int hold_last, input int pulse_at, input int ncyc);
      bus.tiwen = tw1;
      bus.start = 1'b1;
      for (int j = 0; j < ncyc; j++) begin
         @(posedge clk);
         #1;
         ln[j] = bus.RS232_TX;
         bz[j] = bus.busy;
         dn[j] = bus.Tx_done;
         bus.start = (j + 1 <= hold_last) || (j + 1 == pulse_at);
         if (j == change_at) bus.tiwen = tw2;
      end
      bus.start = 1'b0;
   endtask

   task automatic check_frame(input logic [15:0] tw, input int base, input string name);
      int fb;
      logic [9:0] bits;
      logic [9:0] want;
      fb = -1;
      for (int j = 0; j <= FRAME_END; j++)
         if (fb < 0 && ln[base+j] !== exp_line(tw, j)) fb = j;
      total++;
      if (fb >= 0) begin
         bad++;
         $display("FAIL %s line: at clk %0d got %b want %b", name, fb, ln[base+fb], exp_line(tw, fb));
      end
      fb = -1;
      for (int j = 0; j <= FRAME_END; j++)
         if (fb < 0 && bz[base+j] !== (j < FRAME_END)) fb = j;
      total++;
      if (fb >= 0) begin
         bad++;
         $display("FAIL %s busy: at clk %0d got %b want %b", name, fb, bz[base+fb], (fb < FRAME_END));
      end
      fb = -1;
      for (int j = 0; j <= FRAME_END; j++)
         if (fb < 0 && dn[base+j] !== (j == FRAME_END)) fb = j;
      total++;
      if (fb >= 0) begin
         bad++;
         $display("FAIL %s Tx_done: at clk %0d got %b want %b", name, fb, dn[base+fb], (fb == FRAME_END));
      end
      for (int k = 0; k < 5; k++) begin
         for (int b = 0; b < 10; b++) bits[b] = ln[base + 2 + k*SLOT + b*CPB + CPB/2];
         want = {1'b1, exp_byte(tw, k), 1'b0};
         total++;
         if (bits !== want) begin
            bad++;
            $display("FAIL %s byte%0d decode: got %h want %h", name, k, bits, want);
         end
      end
   endtask

   task automatic check_quiet(input int from, input int to, input string name);
      int n;
      n = 0;
      for (int j = from; j < to; j++)
         if (ln[j] !== 1'b1 || bz[j] !== 1'b0 || dn[j] !== 1'b0) n++;
      total++;
      if (n != 0) begin
         bad++;
         $display("FAIL %s quiet: %0d non-idle clks, want 0", name, n);
      end
   endtask

   task automatic test_reset;
      bus.start = 1'b0;
      bus.tiwen = 16'h0000;
      #2 rst = 1'b1;
      @(posedge clk);
      #1;
      total++;
      if (bus.RS232_TX !== 1'b1) begin bad++; $display("FAIL reset line: got %b want 1", bus.RS232_TX); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", bus.busy); end
      total++;
      if (bus.Tx_done !== 1'b0) begin bad++; $display("FAIL reset Tx_done: got %b want 0", bus.Tx_done); end
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_idle;
      for (int j = 0; j < 1000; j++) begin
         @(posedge clk);
         #1;
         ln[j] = bus.RS232_TX;
         bz[j] = bus.busy;
         dn[j] = bus.Tx_done;
      end
      check_quiet(0, 1000, "idle");
   endtask

   task automatic test_basic;
      run_frame(16'h0172, -1, 16'h0000, 0, -1, 530);
      check_frame(16'h0172, 0, "basic");
      check_quiet(FRAME_END + 1, 530, "basic tail");
   endtask

   task automatic test_wrap;
      run_frame(16'hFFFF, -1, 16'h0000, 0, -1, 520);
      check_frame(16'hFFFF, 0, "wrap");
      check_quiet(FRAME_END + 1, 520, "wrap tail");
   endtask

   task automatic test_random;
      logic [15:0] tw;
      logic [15:0] tw_late;
      for (int i = 0; i < 3; i++) begin
         tw      = 16'($urandom);
         tw_late = 16'($urandom);
         run_frame(tw, 200, tw_late, 0, -1, 520);
         check_frame(tw, 0, "random");
         check_quiet(FRAME_END + 1, 520, "random tail");
      end
   endtask

   task automatic test_ignore_restart;
      logic [15:0] tw;
      tw = 16'($urandom);
      run_frame(tw, 49, ~tw, 0, 50, 700);
      check_frame(tw, 0, "restart");
      check_quiet(FRAME_END + 1, 700, "restart tail");
   endtask

   task automatic test_back_to_back;
      logic [15:0] tw1;
      logic [15:0] tw2;
      tw1 = 16'($urandom);
      tw2 = tw1 ^ 16'h3C5A;
      run_frame(tw1, 100, tw2, FRAME_END + 1, -1, 1040);
      check_frame(tw1, 0, "b2b first");
      check_frame(tw2, FRAME_END + 1, "b2b second");
      check_quiet(2 * FRAME_END + 2, 1040, "b2b tail");
   endtask

   task automatic test_reset_mid;
      logic [15:0] tw;
      logic pre;
      tw = 16'h0172;
      bus.tiwen = tw;
      bus.start = 1'b1;
      for (int j = 0; j <= 230; j++) begin
         @(posedge clk);
         #1;
         bus.start = 1'b0;
      end
      pre = bus.RS232_TX;
      total++;
      if (pre !== exp_line(tw, 230)) begin
         bad++;
         $display("FAIL abort pre-reset line: got %b want %b", pre, exp_line(tw, 230));
      end
      #1 rst = 1'b1;
      #1;
      total++;
      if (bus.RS232_TX !== 1'b1) begin bad++; $display("FAIL abort async line: got %b want 1", bus.RS232_TX); end
      total++;
      if (bus.busy !== 1'b0) begin bad++; $display("FAIL abort async busy: got %b want 0", bus.busy); end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int j = 0; j < 400; j++) begin
         @(posedge clk);
         #1;
         ln[j] = bus.RS232_TX;
         bz[j] = bus.busy;
         dn[j] = bus.Tx_done;
      end
      check_quiet(0, 400, "abort");
      tw = 16'($urandom);
      run_frame(tw, -1, 16'h0000, 0, -1, 520);
      check_frame(tw, 0, "after abort");
      check_quiet(FRAME_END + 1, 520, "after abort tail");
   endtask

   initial begin
      test_reset;
      test_idle;
      test_basic;
      test_wrap;
      test_random;
      test_ignore_restart;
      test_back_to_back;
      test_reset_mid;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
